// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
//   Shares the single register-file write port among NREQ writeback
//   requesters (ALU, LSU, CSR, ...). Grants are round-robin starting at ptr;
//   the winning write is registered and presented on rf_* one cycle after the
//   handshake. Writes to x0 are acknowledged but never enable the register file.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      blocks all grants (and pointer movement) this cycle
//   req_valid  per-requester write request
//   req_ready  per-requester grant, combinational, one-hot or zero
//   req_addr   packed destination indices, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rf_wen     registered write enable
//   rf_waddr   registered write address
//   rf_wdata   registered write data
//   grant_id   registered index of the requester whose write is on rf_*
module regfile_wport_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 2,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [IDW-1:0]             grant_id
);

    logic [IDW-1:0]        ptr_q, ptr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDW-1:0]        gid_q, gid_d;

    logic                  found;
    logic [IDW-1:0]        sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // (p + k) mod NREQ for p, k < NREQ; explicit wrap so non-power-of-2
    // NREQ never lands on an unused index.
    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= NREQ) ? s - NREQ : s;
    endfunction

    // Round-robin scan beginning at ptr_q; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[wrap_idx(int'(ptr_q), k)]) begin
                found    = 1'b1;
                sel_idx  = IDW'(wrap_idx(int'(ptr_q), k));
                sel_addr = req_addr[wrap_idx(int'(ptr_q), k)*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[wrap_idx(int'(ptr_q), k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // Reset and flush suppress the handshake entirely, so nothing transfers.
        if (rst || flush) found = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = found && (sel_idx == IDW'(k));
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        if (found) begin
            ptr_d   = (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + IDW'(1);
            wen_d   = (sel_addr != '0);
            waddr_d = sel_addr;
            wdata_d = sel_data;
            gid_d   = sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign rf_wen   = wen_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Testbench for regfile_wport_arbiter with NREQ=3 (exercises the
// non-power-of-2 pointer wrap). A behavioural model tracks the round-robin
// pointer and the expected registered write; an attached register-file array
// captures the DUT's writes and is compared with a model register file.
module tb_regfile_wport_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [IW-1:0]   grant_id;

    regfile_wport_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Register file attached to the write port.
    logic [DW-1:0] rf_dut [32];
    always @(posedge clk) if (rf_wen) rf_dut[rf_waddr] <= rf_wdata;

    int checks = 0;
    int errors = 0;

    // Model state
    int            ptr_m;
    logic          ewen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    int            egid;
    logic [DW-1:0] rf_m [32];
    int            last_g;
    logic [N-1:0]  rdy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // First valid requester at or after ptr_m, wrapping modulo N; -1 if none.
    function automatic int pick();
        if (rst || flush) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    // One clock: check grant before the edge, advance model, check rf_* after.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        rdy_seen = req_ready;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        if (ewen) rf_m[eaddr] = edata;
        last_g = rst ? -1 : g;
        if (rst) begin
            ptr_m = 0; ewen = 0; eaddr = '0; edata = '0; egid = 0;
        end else if (g >= 0) begin
            eaddr = req_addr[g*AW +: AW];
            edata = req_data[g*DW +: DW];
            ewen  = (eaddr != 0);
            egid  = g;
            ptr_m = (g + 1) % N;
        end else begin
            ewen = 0;
        end
        #1;
        chk("rf_wen", rf_wen, ewen);
        chk("rf_waddr", rf_waddr, eaddr);
        chk("rf_wdata", rf_wdata, edata);
        chk("grant_id", grant_id, egid);
        @(negedge clk);
    endtask

    logic          pend [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];

    initial begin
        for (int r = 0; r < 32; r++) begin rf_dut[r] = '0; rf_m[r] = '0; end
        ptr_m = 0; ewen = 0; eaddr = '0; edata = '0; egid = 0;
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;

        // Reset held 2 cycles with every requester valid
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 32'h100 + 32'(i));
        cycle();
        chk("rst_ready0", rdy_seen, 3'b000);
        cycle();
        chk("rst_ready1", rdy_seen, 3'b000);
        rst = 1'b0;

        // Round robin: 0,1,2,0,1,2 with all valid, rf_wen on every output cycle
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_grant", rdy_seen, 3'b001 << (k % 3));
            chk("rr_wen", rf_wen, 1'b1);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        cycle();
        chk("rr_idle_wen", rf_wen, 1'b0);

        // Single requester 1
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("single_ready", rdy_seen, 3'b010);
        chk("single_wen", rf_wen, 1'b1);
        chk("single_addr", rf_waddr, 5'd5);
        chk("single_data", rf_wdata, 32'hDEADBEEF);
        chk("single_gid", grant_id, 2'd1);
        set_req(1, 1'b0, '0, '0);
        cycle();
        chk("single_t2_wen", rf_wen, 1'b0);

        // x0 suppression
        set_req(0, 1'b1, 5'd0, 32'h1234);
        cycle();
        chk("x0_ready", rdy_seen, 3'b001);
        chk("x0_wen", rf_wen, 1'b0);
        chk("x0_gid", grant_id, 2'd0);
        set_req(0, 1'b0, '0, '0);
        cycle();
        chk("x0_reg", rf_dut[0], 32'h0);

        // Flush with ptr=1 and requesters 0,1 valid
        set_req(0, 1'b1, 5'd9, 32'h99);
        set_req(1, 1'b1, 5'd10, 32'hAA);
        flush = 1'b1;
        cycle();
        chk("flush_ready", rdy_seen, 3'b000);
        flush = 1'b0;
        cycle();
        chk("post_flush_ready", rdy_seen, 3'b010);
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        cycle();  // the dropped requester 0 write is abandoned, not transferred

        // Same-address ordering: x3=A from req0 at T, x3=B from req1 at T+1
        set_req(0, 1'b1, 5'd3, 32'hA);
        cycle();
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b1, 5'd3, 32'hB);
        cycle();
        set_req(1, 1'b0, '0, '0);
        cycle();
        chk("order_x3", rf_dut[3], 32'hB);

        // Reset mid-operation: registered write still lands
        set_req(2, 1'b1, 5'd7, 32'h7777);
        cycle();
        set_req(2, 1'b0, '0, '0);
        rst = 1'b1;
        #1 chk("rst_pending_wen", rf_wen, 1'b1);
        cycle();
        rst = 1'b0;
        chk("rst_after_wen", rf_wen, 1'b0);
        chk("rst_x7", rf_dut[7], 32'h7777);

        // Randomised traffic; a requester holds addr/data until its transfer
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 60)) begin
                    pend[i] = 1'b1;
                    pa[i] = AW'($urandom_range(0, 7));
                    pd[i] = $urandom;
                end
                set_req(i, pend[i], pend[i] ? pa[i] : '0, pend[i] ? pd[i] : '0);
            end
            flush = ($urandom_range(0, 9) == 0);
            cycle();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        flush = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        cycle();
        cycle();
        for (int r = 0; r < 32; r++) chk("rf_final", rf_dut[r], rf_m[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
